calc_display_ctrl: RTL and testbench

//  Receiving end of the calculator display stream: samples status/data/pos from

---
 rtl/calc_display_ctrl.sv | 130 +++++++++++++
 tb/tb_calc_display_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_ctrl.sv
// Display end of the calculator digit stream: builds frames in a shadow buffer,
// commits only complete frames, and scans them onto an 8-digit 7-segment display.
module calc_display_ctrl #(
  parameter int PRESCALE = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_upd
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_READY = 2'b10;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  logic [1:0]      status_d;
  logic [3:0]      pos_d;
  logic [7:0][3:0] shadow;
  logic [7:0][3:0] display;
  logic            err;
  logic [PW-1:0]   presc;
  logic [2:0]      idx;

  logic            capture;
  logic            upper_nz;
  logic            blank;
  logic [3:0]      cur;
  logic [6:0]      seg_next;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // data arrives one cycle after its pos/status, so those are delayed to pair up.
  assign capture = (status_d != ST_READY) && !pos_d[3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_d  <= ST_READY;
      pos_d     <= 4'd0;
      shadow    <= '0;
      display   <= '0;
      err       <= 1'b0;
      frame_upd <= 1'b0;
    end else begin
      status_d  <= status;
      pos_d     <= pos;
      frame_upd <= capture && (pos_d == 4'd7);
      if (capture)
        shadow[pos_d[2:0]] <= data;
      // frame_upd marks the cycle after the last digit landed in shadow.
      if (frame_upd)
        display <= shadow;
      if (status_d == ST_ERROR)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    cur      = display[idx];
    upper_nz = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if ((3'(j) >= idx) && (display[j] != 4'd0))
        upper_nz = 1'b1;
    end
    blank    = BLANK_LZ && (idx != 3'd0) && !upper_nz;
    seg_next = SEG_BLANK;
    if (err) begin
      case (idx)
        3'd2:       seg_next = SEG_E;
        3'd1, 3'd0: seg_next = SEG_R;
        default:    seg_next = SEG_BLANK;
      endcase
    end else if (!blank) begin
      seg_next = bcd_to_seg(cur);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= seg_next;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed bench for calc_display_ctrl: streams frames, then reads digits back
// off the multiplexed scan and compares against hand-decoded segment patterns.
module tb_calc_display_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_upd;

  int passed = 0;
  int total  = 0;
  int upd_cnt = 0;
  int u0;

  calc_display_ctrl #(.PRESCALE(4), .BLANK_LZ(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_upd (frame_upd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_upd === 1'b1)
      upd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_digit(input int k, input logic [6:0] exp, input string tag);
    logic [7:0] tgt;
    int n;
    tgt = ~(8'b1 << k);
    n = 0;
    while (an !== tgt && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (an !== tgt) begin
      total++;
      $error("FAIL %s digit %0d never selected: an=%h expected=%h", tag, k, an, tgt);
    end else begin
      chk(tag, {1'b0, seg}, {1'b0, exp});
    end
  endtask

  // digit k of d is d[4k+:4]; data trails pos by one cycle.
  task automatic send_frame(input logic [31:0] d, input int npos, input logic [1:0] st);
    for (int i = 0; i <= npos; i++) begin
      @(negedge clock);
      pos    = (i < npos) ? 4'(i) : 4'hF;
      status = (i < npos) ? st : 2'b10;
      data   = (i > 0) ? d[4*(i-1) +: 4] : 4'h0;
    end
    @(negedge clock);
    data = 4'h0;
  endtask

  initial begin
    reset  = 1'b0;
    status = 2'b10;
    pos    = 4'hF;
    data   = 4'h0;

    // reset values, then first scan slot
    repeat (3) @(negedge clock);
    chk("rst_an",  an, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp",  {7'b0, dp}, 8'h01);
    chk("rst_upd", {7'b0, frame_upd}, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("t1_an0",  an, 8'hFE);
    chk("t1_seg0", {1'b0, seg}, 8'h40);
    check_digit(1, 7'h7F, "t1_d1_blank");
    check_digit(7, 7'h7F, "t1_d7_blank");

    // full frame showing 123
    u0 = upd_cnt;
    send_frame(32'h0000_0123, 8, 2'b01);
    repeat (4) @(negedge clock);
    chk("t2_upd", 8'(upd_cnt - u0), 8'd1);
    check_digit(0, 7'h30, "t2_d0");
    check_digit(1, 7'h24, "t2_d1");
    check_digit(2, 7'h79, "t2_d2");
    check_digit(3, 7'h7F, "t2_d3_blank");
    check_digit(7, 7'h7F, "t2_d7_blank");

    // partial frame of 9s is dropped; a following full frame of 8s replaces all
    u0 = upd_cnt;
    send_frame(32'h0009_9999, 5, 2'b01);
    repeat (4) @(negedge clock);
    chk("t3_no_upd", 8'(upd_cnt - u0), 8'd0);
    check_digit(0, 7'h30, "t3_d0_kept");
    check_digit(2, 7'h79, "t3_d2_kept");
    send_frame(32'h8888_8888, 8, 2'b01);
    repeat (4) @(negedge clock);
    chk("t3_upd8", 8'(upd_cnt - u0), 8'd1);
    check_digit(0, 7'h00, "t3_d0_8");
    check_digit(4, 7'h00, "t3_d4_8");
    check_digit(7, 7'h00, "t3_d7_8");

    // non-BCD digit shows a dash; inner zeros stay lit; pos>7 is ignored
    u0 = upd_cnt;
    send_frame(32'h00C0_0005, 8, 2'b01);
    repeat (4) @(negedge clock);
    chk("t5_upd", 8'(upd_cnt - u0), 8'd1);
    check_digit(5, 7'h3F, "t5_d5_dash");
    check_digit(0, 7'h12, "t5_d0");
    check_digit(3, 7'h40, "t5_d3_zero");
    check_digit(6, 7'h7F, "t5_d6_blank");
    u0 = upd_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      status = 2'b01;
      pos    = 4'd9;
      data   = 4'd7;
    end
    @(negedge clock);
    status = 2'b10;
    pos    = 4'hF;
    data   = 4'h0;
    repeat (4) @(negedge clock);
    chk("t5_pos9_no_upd", 8'(upd_cnt - u0), 8'd0);
    check_digit(0, 7'h12, "t5_pos9_d0");
    check_digit(5, 7'h3F, "t5_pos9_d5");

    // error status latches the Err screen; commits still pulse frame_upd
    u0 = upd_cnt;
    send_frame(32'h0000_0042, 8, 2'b00);
    repeat (4) @(negedge clock);
    chk("t4_upd", 8'(upd_cnt - u0), 8'd1);
    check_digit(2, 7'h06, "t4_d2_E");
    check_digit(1, 7'h2F, "t4_d1_r");
    check_digit(0, 7'h2F, "t4_d0_r");
    check_digit(3, 7'h7F, "t4_d3_blank");
    check_digit(7, 7'h7F, "t4_d7_blank");
    send_frame(32'h0000_0007, 8, 2'b01);
    repeat (4) @(negedge clock);
    chk("t4_upd2", 8'(upd_cnt - u0), 8'd2);
    check_digit(0, 7'h2F, "t4_sticky_d0");
    check_digit(2, 7'h06, "t4_sticky_d2");

    // reset in the middle of a frame
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      status = 2'b01;
      pos    = 4'(i);
      data   = 4'(i + 1);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_rst_an",  an, 8'hFF);
    chk("t6_rst_seg", {1'b0, seg}, 8'h7F);
    chk("t6_rst_dp",  {7'b0, dp}, 8'h01);
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    status = 2'b10;
    pos    = 4'hF;
    data   = 4'h0;
    u0 = upd_cnt;
    repeat (40) @(negedge clock);
    chk("t6_no_upd", 8'(upd_cnt - u0), 8'd0);
    check_digit(0, 7'h40, "t6_d0_zero");
    check_digit(2, 7'h7F, "t6_d2_err_cleared");
    send_frame(32'h0000_0456, 8, 2'b01);
    repeat (4) @(negedge clock);
    chk("t6_upd", 8'(upd_cnt - u0), 8'd1);
    check_digit(0, 7'h02, "t6_d0");
    check_digit(1, 7'h12, "t6_d1");
    check_digit(2, 7'h19, "t6_d2");
    check_digit(3, 7'h7F, "t6_d3_blank");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
